uart_mike_ctrl: RTL and testbench

- Controller in front of the UART_MIKE core.
- TX side: round-robin arbiter that shares the UART transmitter between NUM_REQ requesters. It issues one tx_send pulse per accepted byte and times each frame with a cycle counter, because the UART core exposes no busy output.
- RX side: drains the UART's rx_flag/rx_data into a valid/ready output and handshakes rx_flag_clr back to the UART.

---
 rtl/uart_mike_ctrl.sv | 149 ++++++++++++++
 tb/tb_uart_mike_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mike_ctrl.sv
// uart_mike_ctrl: shares the UART_MIKE transmitter between requesters, times each TX frame, and drains RX bytes.
// Define UART_MIKE_CTRL_FIXED_PRIO_EN for fixed lowest-index-wins arbitration; round-robin by default.
module uart_mike_ctrl #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,    // UART_DATA_WIDTH of the UART_MIKE core
    parameter int FRAME_CYCLES = 110
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_send,
    input  logic                          rx_flag,
    input  logic [DATA_WIDTH-1:0]         rx_data,
    input  logic                          parity_error,
    output logic                          rx_flag_clr,
    output logic                          rx_valid,
    output logic [DATA_WIDTH-1:0]         rx_byte,
    output logic                          rx_perr,
    input  logic                          rx_ready
);
    // state  | meaning
    // IDLE   | TX free, arbitrating
    // WAIT   | frame on the line, counting cnt down to 0
    // R_IDLE | waiting for rx_flag with room in the output slot
    // R_CLR  | rx_flag_clr held until the UART drops rx_flag

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CYCLES - 1);

    typedef enum logic {IDLE, WAIT} tx_state_t;
    typedef enum logic {R_IDLE, R_CLR} rx_state_t;

    tx_state_t     tx_state, tx_state_nxt;
    rx_state_t     rx_state, rx_state_nxt;
    logic [CW-1:0] cnt;
    logic [IW-1:0] winner;
    logic          grant;
    logic          capture;

`ifdef UART_MIKE_CTRL_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) winner = IW'(k);
        end
    end
`else
    logic [IW-1:0] ptr;

    // Walk downward so the closest set bit at or above ptr is the last one written.
    always_comb begin
        int idx;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) winner = IW'(idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end
`endif

    assign busy  = (tx_state == WAIT);
    assign grant = (tx_state == IDLE) && (|req_valid);

    always_comb begin
        tx_state_nxt = tx_state;
        rx_state_nxt = rx_state;
        capture      = 1'b0;
        case (tx_state)
            IDLE:    if (|req_valid) tx_state_nxt = WAIT;
            WAIT:    if (cnt == '0) tx_state_nxt = IDLE;
            default: tx_state_nxt = IDLE;
        endcase
        case (rx_state)
            R_IDLE: begin
                if (rx_flag && (!rx_valid || rx_ready)) begin
                    capture      = 1'b1;
                    rx_state_nxt = R_CLR;
                end
            end
            R_CLR:   if (!rx_flag) rx_state_nxt = R_IDLE;
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    // Reset lands in WAIT so a frame already on the line can finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= WAIT;
            rx_state <= R_IDLE;
        end else begin
            tx_state <= tx_state_nxt;
            rx_state <= rx_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= CNT_LOAD;
            tx_send   <= 1'b0;
            tx_data   <= '0;
            req_ready <= '0;
            grant_id  <= '0;
        end else begin
            tx_send   <= 1'b0;
            req_ready <= '0;
            if (grant) begin
                tx_data   <= req_data[winner*DATA_WIDTH +: DATA_WIDTH];
                tx_send   <= 1'b1;
                req_ready <= NUM_REQ'(1) << winner;
                grant_id  <= winner;
                cnt       <= CNT_LOAD;
            end else if (busy && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid    <= 1'b0;
            rx_byte     <= '0;
            rx_perr     <= 1'b0;
            rx_flag_clr <= 1'b0;
        end else if (capture) begin
            rx_byte     <= rx_data;
            rx_perr     <= parity_error;
            rx_valid    <= 1'b1;
            rx_flag_clr <= 1'b1;
        end else begin
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (rx_state == R_CLR && !rx_flag) rx_flag_clr <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_mike_ctrl.sv
// Scoreboard bench for uart_mike_ctrl: stimulus pushes expected TX/RX bytes, a negedge monitor pops and compares.
// Expectations follow UART_MIKE_CTRL_FIXED_PRIO_EN when it is defined.
module tb_uart_mike_ctrl;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int FC = 110;
`ifdef UART_MIKE_CTRL_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic [1:0]    grant_id;
    logic          busy;
    logic [DW-1:0] tx_data;
    logic          tx_send;
    logic          rx_flag = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          parity_error = 1'b0;
    logic          rx_flag_clr;
    logic          rx_valid;
    logic [DW-1:0] rx_byte;
    logic          rx_perr;
    logic          rx_ready = 1'b0;

    uart_mike_ctrl #(.NUM_REQ(N), .DATA_WIDTH(DW), .FRAME_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .grant_id(grant_id), .busy(busy), .tx_data(tx_data),
        .tx_send(tx_send), .rx_flag(rx_flag), .rx_data(rx_data),
        .parity_error(parity_error), .rx_flag_clr(rx_flag_clr), .rx_valid(rx_valid),
        .rx_byte(rx_byte), .rx_perr(rx_perr), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [1:0] id; logic [7:0] data; } tx_exp_t;
    typedef struct packed { logic [7:0] b; logic p; } rx_exp_t;
    tx_exp_t txq[$];
    rx_exp_t rxq[$];
    tx_exp_t te;
    rx_exp_t re;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_send = -1;
    int gap_exp = 0;
    int gap_from = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (tx_send) begin
            if (txq.size() == 0) begin
                check("tx_unexpected_send", 32'(tx_send), 32'(0));
            end else begin
                te = txq.pop_front();
                check("tx_data", 32'(tx_data), 32'(te.data));
                check("grant_id", 32'(grant_id), 32'(te.id));
                check("req_ready", 32'(req_ready), 32'(4'b0001 << te.id));
            end
            if (gap_exp != 0 && last_send > gap_from)
                check("tx_gap", 32'(cyc - last_send), 32'(gap_exp));
            last_send = cyc;
        end
        if (rx_valid && rx_ready) begin
            if (rxq.size() == 0) begin
                check("rx_unexpected_pop", 32'(rx_valid), 32'(0));
            end else begin
                re = rxq.pop_front();
                check("rx_byte", 32'(rx_byte), 32'(re.b));
                check("rx_perr", 32'(rx_perr), 32'(re.p));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int exp_n);
        int n = 0;
        while (busy && n < FC + 10) begin
            tick();
            n++;
        end
        check(name, 32'(n), 32'(exp_n));
    endtask

    task automatic wait_send(input string name, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_send && n < FC + 10);
        check({name, "_send"}, 32'(tx_send), 32'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wait_idle("reset_idle", FC);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [1:0] first_id;

        rst = 1'b1;
        tick(); tick(); tick();
        check("rst_tx_send", 32'(tx_send), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_grant_id", 32'(grant_id), 32'(0));
        check("rst_busy", 32'(busy), 32'(1));
        check("rst_rx_valid", 32'(rx_valid), 32'(0));
        check("rst_rx_byte", 32'(rx_byte), 32'(0));
        check("rst_rx_perr", 32'(rx_perr), 32'(0));
        check("rst_rx_flag_clr", 32'(rx_flag_clr), 32'(0));
        rst = 1'b0;
        wait_idle("rst_busy_len", FC);

        // single request from requester 1
        req_data  = {8'hEE, 8'hDD, 8'h55, 8'hBB};
        req_valid = 4'b0010;
        txq.push_back('{2'd1, 8'h55});
        wait_send("single", n);
        check("single_latency", 32'(n), 32'(1));
        req_valid = 4'b0000;
        wait_idle("single_busy_len", FC);
        check("single_hold", 32'(tx_data), 32'(8'h55));

        // reset 20 cycles into a frame, with the request still held
        req_data[7:0] = 8'h77;
        req_valid     = 4'b0001;
        txq.push_back('{2'd0, 8'h77});
        wait_send("rmf_first", n);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        check("rmf_tx_send", 32'(tx_send), 32'(0));
        check("rmf_busy", 32'(busy), 32'(1));
        check("rmf_req_ready", 32'(req_ready), 32'(0));
        txq.push_back('{2'd0, 8'h77});
        rst = 1'b0;
        wait_send("rmf_second", n);
        check("rmf_latency", 32'(n), 32'(FC + 1));
        req_valid = 4'b0000;

        do_reset();

        // fairness: all four held valid
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 5; i++) begin
            first_id = FIXED ? 2'd0 : 2'(i % 4);
            txq.push_back('{first_id, 8'hA0 + 8'(first_id)});
        end
        gap_exp  = FC + 1;
        gap_from = cyc;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) wait_send("fair", n);
        req_valid = 4'b0000;
        wait_idle("fair_idle", FC);
        gap_exp = 0;

        // wrap: grant 2 moves ptr to 3, then 3 and 0 contend
        req_valid = 4'b0100;
        txq.push_back('{2'd2, 8'hA2});
        wait_send("wrap_pre", n);
        req_valid = 4'b0000;
        wait_idle("wrap_pre_idle", FC);
        req_data  = {8'hD3, 8'hA2, 8'hA1, 8'hD0};
        first_id  = FIXED ? 2'd0 : 2'd3;
        txq.push_back('{first_id, first_id == 2'd3 ? 8'hD3 : 8'hD0});
        txq.push_back('{first_id == 2'd3 ? 2'd0 : 2'd3, first_id == 2'd3 ? 8'hD0 : 8'hD3});
        req_valid = 4'b1001;
        wait_send("wrap_a", n);
        req_valid = (first_id == 2'd3) ? 4'b0001 : 4'b1000;
        wait_send("wrap_b", n);
        check("wrap_spacing", 32'(n), 32'(FC + 1));
        req_valid = 4'b0000;
        wait_idle("wrap_idle", FC);

        // RX drain with backpressure
        rx_ready     = 1'b0;
        rx_flag      = 1'b1;
        rx_data      = 8'h3C;
        parity_error = 1'b1;
        rxq.push_back('{8'h3C, 1'b1});
        tick();
        check("rx_cap_valid", 32'(rx_valid), 32'(1));
        check("rx_cap_byte", 32'(rx_byte), 32'(8'h3C));
        check("rx_cap_perr", 32'(rx_perr), 32'(1));
        check("rx_cap_clr", 32'(rx_flag_clr), 32'(1));
        tick(); tick();
        check("rx_clr_held", 32'(rx_flag_clr), 32'(1));
        rx_flag = 1'b0;
        tick();
        check("rx_clr_drop", 32'(rx_flag_clr), 32'(0));
        rx_flag      = 1'b1;
        rx_data      = 8'h5A;
        parity_error = 1'b0;
        tick(); tick();
        check("rx_bp_noclr", 32'(rx_flag_clr), 32'(0));
        check("rx_bp_byte", 32'(rx_byte), 32'(8'h3C));
        check("rx_bp_valid", 32'(rx_valid), 32'(1));

        // consume and capture at the same edge
        rxq.push_back('{8'h5A, 1'b0});
        rx_ready = 1'b1;
        tick();
        check("rx_sim_valid", 32'(rx_valid), 32'(1));
        check("rx_sim_byte", 32'(rx_byte), 32'(8'h5A));
        check("rx_sim_perr", 32'(rx_perr), 32'(0));
        check("rx_sim_clr", 32'(rx_flag_clr), 32'(1));
        rx_flag = 1'b0;
        tick();
        rx_ready = 1'b0;
        check("rx_end_valid", 32'(rx_valid), 32'(0));
        check("rx_end_clr", 32'(rx_flag_clr), 32'(0));
        tick();

        check("txq_drained", 32'(txq.size()), 32'(0));
        check("rxq_drained", 32'(rxq.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
